// File: rtl/ssd_instr_deserializer.sv
// Reassembles 7-beat SSD instruction frames from the 64-bit compression stream
// into one packed ssd_instr_t, with framing/padding checks and status counters.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_COLLECT | accepting beats 0..6 of a frame, beat_cnt tracks position
// ST_DISCARD | over-long frame seen, consume and drop beats up to tlast
module ssd_instr_deserializer #(
  parameter int DATA_BITS    = 64,
  parameter int INSTR_BITS   = 418,
  parameter int BEATS        = 7,
  parameter int ERR_CNT_BITS = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_BITS-1:0]    s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [INSTR_BITS-1:0]   m_instr,
  output logic                    m_instr_valid,
  input  logic                    m_instr_ready,
  output logic                    err_frame,
  output logic                    err_pad,
  output logic [31:0]             instr_count,
  output logic [ERR_CNT_BITS-1:0] err_count
);

  localparam int CNT_BITS  = $clog2(BEATS);
  localparam int ACC_BITS  = DATA_BITS * (BEATS - 1);
  localparam int TAIL_BITS = INSTR_BITS - ACC_BITS;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(BEATS - 1);

  typedef enum logic [0:0] {
    ST_COLLECT,
    ST_DISCARD
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [ACC_BITS-1:0]     acc_q;
  logic [INSTR_BITS-1:0]   instr_q;
  logic                    valid_q;
  logic                    err_frame_q, err_pad_q;
  logic [31:0]             instr_cnt_q;
  logic [ERR_CNT_BITS-1:0] err_cnt_q;

  logic tready;
  logic store;
  logic load;
  logic err_frame_d;
  logic err_pad_d;
  logic pad_nz;
  logic out_hs;

  assign pad_nz = |s_axis_tdata[DATA_BITS-1:TAIL_BITS];
  assign out_hs = valid_q && m_instr_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The final beat is only taken when the output register can accept the
  // new instruction this cycle, hence the combinational m_instr_ready path.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tready      = 1'b1;
    store       = 1'b0;
    load        = 1'b0;
    err_frame_d = 1'b0;
    err_pad_d   = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        if (cnt_q == LAST_CNT) begin
          tready = !valid_q || m_instr_ready;
        end
        if (s_axis_tvalid && tready) begin
          if (cnt_q != LAST_CNT) begin
            if (s_axis_tlast) begin
              err_frame_d = 1'b1;
              cnt_d       = '0;
            end else begin
              store = 1'b1;
              cnt_d = cnt_q + CNT_BITS'(1);
            end
          end else begin
            cnt_d = '0;
            if (!s_axis_tlast) begin
              err_frame_d = 1'b1;
              state_d     = ST_DISCARD;
            end else if (pad_nz) begin
              err_pad_d = 1'b1;
            end else begin
              load = 1'b1;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        cnt_d   = '0;
      end
    endcase
  end

  // Shift register: every accepted frame stores exactly six beats before the
  // load, so beat 0 always lands in the low word regardless of earlier drops.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q <= '0;
    end else if (store) begin
      acc_q <= {s_axis_tdata, acc_q[ACC_BITS-1:DATA_BITS]};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= {s_axis_tdata[TAIL_BITS-1:0], acc_q};
      valid_q <= 1'b1;
    end else if (out_hs) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_frame_q <= 1'b0;
      err_pad_q   <= 1'b0;
    end else begin
      err_frame_q <= err_frame_d;
      err_pad_q   <= err_pad_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      instr_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (out_hs && (instr_cnt_q != '1)) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
      if ((err_frame_d || err_pad_d) && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_BITS'(1);
      end
    end
  end

  assign s_axis_tready = tready;
  assign m_instr       = instr_q;
  assign m_instr_valid = valid_q;
  assign err_frame     = err_frame_q;
  assign err_pad       = err_pad_q;
  assign instr_count   = instr_cnt_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_ssd_instr_deserializer.sv
// Scoreboard bench for ssd_instr_deserializer: directed frames from the test
// plan followed by randomized frames, with backpressure, checked against a packet model.
module tb_ssd_instr_deserializer;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [63:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [417:0] m_instr;
  logic         m_instr_valid;
  logic         m_instr_ready = 1'b0;
  logic         err_frame;
  logic         err_pad;
  logic [31:0]  instr_count;
  logic [15:0]  err_count;

  ssd_instr_deserializer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_instr       (m_instr),
    .m_instr_valid (m_instr_valid),
    .m_instr_ready (m_instr_ready),
    .err_frame     (err_frame),
    .err_pad       (err_pad),
    .instr_count   (instr_count),
    .err_count     (err_count)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  logic [417:0] sb[$];
  int exp_good = 0, exp_err = 0, exp_frame_pulses = 0, exp_pad_pulses = 0;
  int seen_frame = 0, seen_pad = 0;
  int ready_mode = 1;
  bit gaps = 1'b0;
  bit bp_done = 1'b0;

  task automatic check(input string name, input logic [447:0] act, input logic [447:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A packet is the beat sequence up to tlast; only a 7-beat packet with
  // zero padding yields an instruction, any other length is one framing error.
  task automatic model_pkt(input logic [447:0] p, input int len);
    logic [29:0] pad;
    pad = p[447:418];
    if (len != 7) begin
      exp_err++;
      exp_frame_pulses++;
    end else if (pad != 30'd0) begin
      exp_err++;
      exp_pad_pulses++;
    end else begin
      exp_good++;
      sb.push_back(p[417:0]);
    end
  endtask

  always @(posedge aclk) begin
    #1;
    case (ready_mode)
      0:       m_instr_ready = 1'b0;
      1:       m_instr_ready = 1'b1;
      default: m_instr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic         held_pending = 1'b0;
  logic [417:0] held;
  always @(negedge aclk) begin
    if (!aresetn) begin
      held_pending = 1'b0;
    end else begin
      if (err_frame) seen_frame++;
      if (err_pad) seen_pad++;
      if (held_pending) begin
        check("hold_valid", m_instr_valid, 1);
        check("hold_data", m_instr, held);
      end
      if (m_instr_valid && m_instr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got %0h expected none", m_instr);
        end else begin
          check("instr", m_instr, sb.pop_front());
        end
        held_pending = 1'b0;
      end else if (m_instr_valid) begin
        held_pending = 1'b1;
        held = m_instr;
      end else begin
        held_pending = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_beat(input logic [63:0] data, input logic last);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!acc) check("beat_accept_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [447:0] p, input int len);
    logic [63:0] d;
    model_pkt(p, len);
    for (int k = 0; k < len; k++) begin
      if (k < 7) d = p[k*64 +: 64];
      else d = {$urandom, $urandom};
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge aclk);
          #1;
        end
      end
      drive_beat(d, k == len - 1);
    end
  endtask

  function automatic logic [447:0] rand_instr();
    logic [447:0] r;
    for (int i = 0; i < 14; i++) r[i*32 +: 32] = $urandom;
    r[447:418] = '0;
    return r;
  endfunction

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_instr_valid) && n < 1000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_timeout", n >= 1000, 0);
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    logic [447:0] p, p1, p2;
    logic [29:0]  pad;
    int           kind, n;

    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #12;
    check("rst_valid", m_instr_valid, 0);
    check("rst_instr", m_instr, 0);
    check("rst_err_frame", err_frame, 0);
    check("rst_err_pad", err_pad, 0);
    check("rst_instr_count", instr_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_tready", s_axis_tready, 1);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (2) begin
      @(posedge aclk);
      #1;
    end

    // Reset after beat 4 of a frame: partial frame vanishes.
    for (int k = 0; k < 5; k++) drive_beat({$urandom, $urandom}, 1'b0);
    aresetn = 1'b0;
    #1;
    check("midrst_valid", m_instr_valid, 0);
    check("midrst_instr", m_instr, 0);
    check("midrst_instr_count", instr_count, 0);
    check("midrst_err_count", err_count, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send_pkt(rand_instr(), 7);
    wait_drain();
    check("after_rst_instr_count", instr_count, 1);
    check("after_rst_err_count", err_count, 0);

    // Directed READ instruction; valid must be up right after the last beat.
    p = '0;
    p[1:0]     = 2'd2;
    p[65:2]    = 64'h100;
    p[97:66]   = 32'd8;
    p[417:162] = {32{8'hA5}};
    send_pkt(p, 7);
    check("valid_latency", m_instr_valid, 1);
    check("read_instr_direct", m_instr, p[417:0]);
    wait_drain();
    check("read_instr_count", instr_count, 2);

    // Backpressure: two frames while the consumer stalls.
    ready_mode = 0;
    @(posedge aclk);
    #1;
    p1 = rand_instr();
    p2 = rand_instr();
    fork
      begin
        send_pkt(p1, 7);
        send_pkt(p2, 7);
        bp_done = 1'b1;
      end
    join_none
    repeat (20) @(posedge aclk);
    @(negedge aclk);
    check("bp_tready", s_axis_tready, 0);
    check("bp_tvalid", s_axis_tvalid, 1);
    check("bp_valid", m_instr_valid, 1);
    check("bp_held_first", m_instr, p1[417:0]);
    ready_mode = 1;
    n = 0;
    while (!bp_done && n < 500) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("bp_timeout", n >= 500, 0);
    wait_drain();
    check("bp_instr_count", instr_count, 4);

    // Early tlast on beat 3.
    send_pkt(rand_instr(), 4);
    send_pkt(rand_instr(), 7);
    wait_drain();
    check("early_err_count", err_count, 1);
    check("early_pulses", seen_frame, 1);
    check("early_instr_count", instr_count, 5);

    // Missing tlast at beat 6, tlast on beat 9.
    send_pkt(rand_instr(), 10);
    send_pkt(rand_instr(), 7);
    wait_drain();
    check("long_err_count", err_count, 2);
    check("long_pulses", seen_frame, 2);
    check("long_instr_count", instr_count, 6);

    // Padding bit 40 of beat 6 set.
    p = rand_instr();
    p[6*64 + 40] = 1'b1;
    send_pkt(p, 7);
    wait_drain();
    check("pad_err_count", err_count, 3);
    check("pad_pulses", seen_pad, 1);
    check("pad_instr_count", instr_count, 6);

    // Randomized mix with random consumer stalls and source gaps.
    ready_mode = 2;
    gaps = 1'b1;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      p = rand_instr();
      if (kind < 7) begin
        send_pkt(p, 7);
      end else if (kind == 7) begin
        send_pkt(p, $urandom_range(1, 6));
      end else if (kind == 8) begin
        send_pkt(p, $urandom_range(8, 11));
      end else begin
        pad = 30'($urandom);
        if (pad == 30'd0) pad = 30'd1;
        p[447:418] = pad;
        send_pkt(p, 7);
      end
    end
    ready_mode = 1;
    wait_drain();
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    check("final_sb_empty", sb.size(), 0);
    check("final_instr_count", instr_count, exp_good);
    check("final_err_count", err_count, exp_err);
    check("final_frame_pulses", seen_frame, exp_frame_pulses);
    check("final_pad_pulses", seen_pad, exp_pad_pulses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
